// File: rtl/fifo_serializer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_serializer_pkg
//
// Purpose:
//   Shared definitions for the record-to-word serializer. It holds the output
//   word width, the number of words per record, the serializer state encoding
//   and the positions of the named fields inside a record.
//
// Record layout (word k occupies bits [WIDTH*k +: WIDTH]):
//   k = IDX_A        -> field a
//   k = IDX_B        -> field b
//   k = IDX_C0 + i   -> field c[i], i = 0..19
// ---------------------------------------------------------------------------
package fifo_serializer_pkg;

    localparam int WIDTH = 32;
    localparam int WORDS = 22;
    localparam int CNTW  = 5;

    // Word indices of the named record fields.
    localparam int IDX_A  = 0;
    localparam int IDX_B  = 1;
    localparam int IDX_C0 = 2;

    // HDR is only reachable when the header option is compiled in. It stays in
    // the encoding unconditionally so the state register has the same width
    // and meaning in both builds.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SEND = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_word_serializer.sv
// ---------------------------------------------------------------------------
// fifo_word_serializer
//
// Purpose:
//   Takes one WORDS-word record from the upstream record FIFO and replays it
//   as WORDS consecutive WIDTH-bit beats toward a narrow channel. One record
//   is held locally. A new record is accepted on the same cycle the last word
//   of the current one is taken, so consecutive records stream with no idle
//   cycle in between.
//
// Ports:
//   CLK          in   1            clock, all state changes on the rising edge
//   RST          in   1            asynchronous active-high reset
//   in_enq__ENA  in   1            upstream record transfer (only when RDY=1)
//   in_enq_v     in   WIDTH*WORDS  record, word k = bits [WIDTH*k +: WIDTH]
//   in_enq__RDY  out  1            a record can be taken this cycle
//   out_enq__ENA out  1            an output word is valid this cycle
//   out_enq_v    out  WIDTH        current output word (0 while idle)
//   out_enq__RDY in   1            downstream takes the word this cycle
//
// Build option:
//   SERIALIZER_HEADER_EN - when defined, every record is preceded by one
//   header word {16'(WORDS), seq}, where seq is a 16-bit record counter that
//   starts at 0 and advances (with wrap) each time a header is taken. A record
//   then occupies WORDS+1 output beats. When undefined there is no header
//   state and no sequence counter.
//
// Timing notes:
//   out_enq__ENA and out_enq_v come straight from registers, so they never
//   depend on out_enq__RDY in the same cycle. in_enq__RDY is the only
//   combinational path and runs from out_enq__RDY only.
// ---------------------------------------------------------------------------
module fifo_word_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int WIDTH = fifo_serializer_pkg::WIDTH,
    parameter int WORDS = fifo_serializer_pkg::WORDS,
    // Must satisfy 2**CNTW >= WORDS+1.
    parameter int CNTW  = fifo_serializer_pkg::CNTW
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_enq__ENA,
    input  logic [WIDTH*WORDS-1:0]   in_enq_v,
    output logic                     in_enq__RDY,
    output logic                     out_enq__ENA,
    output logic [WIDTH-1:0]         out_enq_v,
    input  logic                     out_enq__RDY
);

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WORDS - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                   state_reg;
    logic [CNTW-1:0]          cnt_reg;
    logic [WIDTH*WORDS-1:0]   buffer_reg;
    logic                     out_ena_reg;
    logic [WIDTH-1:0]         out_word_reg;
`ifdef SERIALIZER_HEADER_EN
    logic [15:0]              seq_reg;
`endif

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    logic in_fire;
    logic out_fire;
    logic last;

    assign last        = (state_reg == SEND) && (cnt_reg == LAST_IDX);
    assign in_enq__RDY = (state_reg == IDLE) || (last && out_enq__RDY);
    assign in_fire     = in_enq__ENA && in_enq__RDY;
    assign out_fire    = out_ena_reg && out_enq__RDY;

    assign out_enq__ENA = out_ena_reg;
    assign out_enq_v    = out_word_reg;

    // -----------------------------------------------------------------------
    // Word view of the buffered record, so the next word to present is a
    // plain array lookup instead of a wide shifter.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] word_arr [WORDS];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word_view
            assign word_arr[gi] = buffer_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Index of the word that follows the current one. Only used while
    // cnt_reg < WORDS-1, so it never points past the last word.
    logic [CNTW-1:0] cnt_inc;
    assign cnt_inc = cnt_reg + CNTW'(1);

    // First beat produced for a freshly accepted record.
    logic [WIDTH-1:0] first_word;
    state_t           first_state;

`ifdef SERIALIZER_HEADER_EN
    // The header carries the sequence number of the record it introduces;
    // seq_reg only advances once that header has actually been taken.
    assign first_word  = {16'(WORDS), seq_reg};
    assign first_state = HDR;
`else
    assign first_word  = in_enq_v[IDX_A*WIDTH +: WIDTH];
    assign first_state = SEND;
`endif

    // -----------------------------------------------------------------------
    // Serializer FSM. The output word is loaded one cycle ahead: whenever the
    // current beat is taken, the register is refilled with the beat that
    // follows, which keeps the output registered and still bubble-free.
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            buffer_reg   <= '0;
            out_ena_reg  <= 1'b0;
            out_word_reg <= '0;
`ifdef SERIALIZER_HEADER_EN
            seq_reg      <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_fire) begin
                        buffer_reg   <= in_enq_v;
                        cnt_reg      <= '0;
                        state_reg    <= first_state;
                        out_ena_reg  <= 1'b1;
                        out_word_reg <= first_word;
                    end
                end

`ifdef SERIALIZER_HEADER_EN
                HDR: begin
                    if (out_fire) begin
                        seq_reg      <= seq_reg + 16'd1;
                        cnt_reg      <= '0;
                        state_reg    <= SEND;
                        out_word_reg <= word_arr[IDX_A];
                    end
                end
`endif

                SEND: begin
                    if (out_fire) begin
                        if (!last) begin
                            cnt_reg      <= cnt_inc;
                            out_word_reg <= word_arr[cnt_inc];
                        end else if (in_fire) begin
                            // Back-to-back: next record replaces the one whose
                            // last word is leaving this very cycle.
                            buffer_reg   <= in_enq_v;
                            cnt_reg      <= '0;
                            state_reg    <= first_state;
                            out_word_reg <= first_word;
                        end else begin
                            cnt_reg      <= '0;
                            state_reg    <= IDLE;
                            out_ena_reg  <= 1'b0;
                            out_word_reg <= '0;
                        end
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    cnt_reg      <= '0;
                    out_ena_reg  <= 1'b0;
                    out_word_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_fifo_word_serializer
//
// Scoreboard bench for fifo_word_serializer. Every accepted record pushes its
// expected output beats into a queue; an independent monitor pops and checks
// one entry per output beat. Build with +define+SERIALIZER_HEADER_EN to cover
// the header option.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_word_serializer;

    localparam int WIDTH = 32;
    localparam int WORDS = 22;
`ifdef SERIALIZER_HEADER_EN
    localparam int REC_BEATS = WORDS + 1;
`else
    localparam int REC_BEATS = WORDS;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_ena = 1'b0;
    logic [WIDTH*WORDS-1:0] in_v = '0;
    logic                   in_rdy;
    logic                   out_ena;
    logic [WIDTH-1:0]       out_v;
    logic                   out_rdy = 1'b1;

    fifo_word_serializer dut (
        .CLK          (clk),
        .RST          (rst),
        .in_enq__ENA  (in_ena),
        .in_enq_v     (in_v),
        .in_enq__RDY  (in_rdy),
        .out_enq__ENA (out_ena),
        .out_enq_v    (out_v),
        .out_enq__RDY (out_rdy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] exp_q [$];
    int               fire_cyc [$];
    int               cyc = 0;
    int               beat_cnt = 0;
    logic [15:0]      exp_seq = 16'd0;
    bit               bp_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Downstream ready: always 1, or the 1,0,0,1 pattern in backpressure mode.
    int bp_idx = 0;
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            out_rdy = (bp_idx % 4 == 0) || (bp_idx % 4 == 3);
            bp_idx++;
        end else begin
            out_rdy = 1'b1;
        end
    end

    // Upstream must never request while the block is not ready.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(in_ena && !in_rdy))
                else $error("[TB] FAIL protocol: in_ena with in_rdy=0");
        end
    end

    // Monitor: at each falling edge, a beat that will fire on the next rising
    // edge is popped and compared; a stalled beat must not change.
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_v = '0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_ena_hold", {31'd0, out_ena}, 32'd1);
                check("stall_word_hold", out_v, prev_v);
            end
            if (out_ena && out_rdy) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_beat: got 0x%08h, required no beat", out_v);
                end else begin
                    check("beat", out_v, exp_q.pop_front());
                end
                fire_cyc.push_back(cyc);
                beat_cnt++;
            end
            prev_stall = out_ena && !out_rdy;
            prev_v     = out_v;
        end
    end

    function automatic logic [WIDTH*WORDS-1:0] make_rec(input logic [31:0] base);
        logic [WIDTH*WORDS-1:0] r;
        r = '0;
        for (int k = 0; k < WORDS; k++) r[k*WIDTH +: WIDTH] = base + 32'(k);
        return r;
    endfunction

    // Entered and left at posedge+2. Waits for in_rdy, drives one transfer,
    // and queues the hand-derived beats of that record.
    task automatic issue_record(input logic [31:0] base);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (in_rdy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("[TB] FAIL in_rdy_timeout: got 0, required 1 within 400 cycles");
        end else begin
            in_ena = 1'b1;
            in_v   = make_rec(base);
`ifdef SERIALIZER_HEADER_EN
            exp_q.push_back({16'(WORDS), exp_seq});
            exp_seq = exp_seq + 16'd1;
`endif
            for (int k = 0; k < WORDS; k++) exp_q.push_back(base + 32'(k));
            @(posedge clk); #2;
            in_ena = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(posedge clk); #2;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_drain_timeout: got %0d beats pending, required 0", name, exp_q.size());
        end
        @(posedge clk); #2;
    endtask

    task automatic check_idle(input string name);
        check({name, "_in_rdy"}, {31'd0, in_rdy}, 32'd1);
        check({name, "_out_ena"}, {31'd0, out_ena}, 32'd0);
        check({name, "_out_v"}, out_v, 32'd0);
    endtask

    logic [31:0] first_exp;

    initial begin
        // Reset then idle
        repeat (3) @(posedge clk);
        #2;
        check_idle("in_reset");
        rst = 1'b0;
        @(posedge clk); #2;
        check_idle("after_reset");

        // Single record, downstream always ready
`ifdef SERIALIZER_HEADER_EN
        first_exp = {16'(WORDS), exp_seq};
`else
        first_exp = 32'h1000;
`endif
        issue_record(32'h1000);
        check("latency_ena", {31'd0, out_ena}, 32'd1);
        check("latency_word", out_v, first_exp);
        drain("single");
        check_idle("single_end");

        // Backpressure 1,0,0,1
        bp_mode = 1'b1;
        @(posedge clk); #2;
        issue_record(32'h1000);
        drain("backpressure");
        bp_mode = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_idle("bp_end");

        // Back-to-back records
        fire_cyc.delete();
        issue_record(32'h1000);
        issue_record(32'h2000);
        drain("b2b");
        check("b2b_fires", 32'(fire_cyc.size()), 32'(2 * REC_BEATS));
        if (fire_cyc.size() == 2 * REC_BEATS)
            check("b2b_span", 32'(fire_cyc[2*REC_BEATS-1] - fire_cyc[0]), 32'(2 * REC_BEATS - 1));
        check_idle("b2b_end");

        // Reset mid-record, after the 7th beat
        beat_cnt = 0;
        issue_record(32'h3000);
        for (int i = 0; i < 100 && beat_cnt < 7; i++) begin
            @(posedge clk); #2;
        end
        check("midrst_beats_seen", 32'(beat_cnt), 32'd7);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("midrst_async_ena", {31'd0, out_ena}, 32'd0);
        check("midrst_async_v", out_v, 32'd0);
        exp_q.delete();
        exp_seq = 16'd0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        beat_cnt = 0;
        repeat (6) @(posedge clk);
        #2;
        check("midrst_no_residual", 32'(beat_cnt), 32'd0);
        check_idle("midrst_idle");
        issue_record(32'h4000);
        drain("after_midrst");
        check_idle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_word_serializer.md
Name: fifo_word_serializer

Overview:
- Downstream consumer of the ping-pong 704-bit record FIFO; takes one 22-word record (a, b, c0..c19, 32 bits each) per enq and emits it as 22 sequential 32-bit enq beats toward the narrow indication/transport channel.
- Holds one record in a local buffer.
- Accepts the next record on the same cycle the last word is taken, so back-to-back records stream without bubbles.

Parameters:
- WIDTH, 32, width of one output word.
- WORDS, 22, number of words per record; the record width is WIDTH*WORDS = 704.
- CNTW, 5, counter width; must satisfy 2**CNTW >= WORDS+1.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- in$enq__ENA  input  1  upstream record transfer request; only legal when in$enq__RDY=1.
- in$enq$v  input  704  record; word k is bits [32k+31:32k] (k=0 is a, k=1 is b, k=2+i is ci).
- in$enq__RDY  output  1  block can accept a record this cycle.
- out$enq__ENA  output  1  an output word is valid this cycle.
- out$enq$v  output  32  current output word.
- out$enq__RDY  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset is asynchronous, active-high, on RST:
  - state=IDLE, cnt=0, buffer=0.
  - At reset, in$enq__RDY=1, out$enq__ENA=0, out$enq$v=0.
- Handshake rules:
  - Input fires when in$enq__ENA & in$enq__RDY.
  - Output beat fires when out$enq__ENA & out$enq__RDY.
  - out$enq__ENA never depends combinationally on out$enq__RDY.
- State machine IDLE/SEND:
  - IDLE: in$enq__RDY=1, out$enq__ENA=0. On input fire, latch the record into the buffer, cnt<=0, go to SEND.
  - SEND: out$enq__ENA=1, out$enq$v=buffer word[cnt]. On output fire with cnt<WORDS-1, cnt<=cnt+1.
  - last = SEND & (cnt==WORDS-1).
  - On output fire when last: if input also fires the same cycle, latch the new record, cnt<=0, stay in SEND; otherwise go to IDLE, cnt<=0.
- in$enq__RDY = IDLE | (last & out$enq__RDY). This is combinational through out$enq__RDY only.
- Latency: first word is valid the cycle after input fire. A full record occupies exactly 22 output fires.
- Stall: out$enq__RDY=0 holds cnt, out$enq$v and out$enq__ENA stable.
- Boundary conditions:
  - cnt never exceeds WORDS-1; no wrap beyond that.
  - An in$enq__ENA without RDY is a protocol violation; the bench asserts on it and the design ignores it.
  - Reset mid-record discards the buffered record with no partial output afterwards.
- out$enq$v is driven 0 in IDLE.

Optional Feature:
- Macro: SERIALIZER_HEADER_EN.
- When defined:
  - Adds a HDR state between input fire and the first data word.
  - HDR emits the word {16'(WORDS), 16'(seq)}, where seq is a 16-bit record counter that resets to 0 and increments on each HDR fire, wrapping 0xFFFF to 0x0000.
  - Each record then takes 23 output fires.
  - The back-to-back accept on the last data word transitions to HDR instead of SEND.
- When undefined: no HDR state and no seq register; behaviour is exactly as above.

Decomposition:
- Shared package fifo_serializer_pkg holds:
  - WIDTH and WORDS constants;
  - state enum {IDLE, HDR, SEND};
  - word-index helper constants (IDX_A=0, IDX_B=1, IDX_C0=2).
- No sub-module needed. Word select is an indexed part-select of the buffer; a separate mux module adds nothing.

Test Plan:
- Reset then idle: assert RST for 3 cycles and release -> in$enq__RDY=1, out$enq__ENA=0, out$enq$v=0.
- Single record with word k=32'h1000+k and out$enq__RDY=1 always -> 22 consecutive beats 0x1000..0x1015 starting the cycle after enq, then IDLE.
- Backpressure: same record, toggle out$enq__RDY 1,0,0,1 repeatedly -> values hold during stalls, no word lost or duplicated, order a,b,c0..c19.
- Back-to-back: second record (0x2000+k) offered continuously -> accepted on the cycle word 0x1015 fires; 0x2000 follows immediately with no idle cycle; 44 fires in 44 cycles.
- Reset mid-record: assert RST after the 7th beat -> out$enq__ENA=0 asynchronously; after release, no residual words; a new record sends from k=0.
- With SERIALIZER_HEADER_EN: two records -> headers 0x00160000 and 0x00160001 precede the respective 22 data words; 46 fires total.
